inst_loader: RTL and testbench



---
 rtl/inst_loader_pkg.sv | 19 +
 rtl/inst_loader_if.sv | 29 ++
 rtl/inst_loader_byte_packer.sv | 37 +++
 rtl/inst_loader.sv | 150 +++++++++++++++
 tb/tb_inst_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package inst_loader_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 8192;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [7:0] ACK_OK  = 8'hAA;
  localparam logic [7:0] ACK_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_ACK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// UART byte stream, BRAM write port and status signals of the loader.
interface inst_loader_if;
  import inst_loader_pkg::*;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              err;

  // Loader side
  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output mem_we, mem_addr, mem_wd, tx_valid, tx_data, busy, done, err
  );

  // Environment side (UART, memory mux, core reset release)
  modport master (
    output rx_valid, rx_data, tx_ready,
    input  mem_we, mem_addr, mem_wd, tx_valid, tx_data, busy, done, err
  );

endinterface

// File: rtl/inst_loader_byte_packer.sv
// Big-endian 4-byte assembler; word_valid_c_o flags the byte that completes a word.
module byte_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_c_o,
  output logic [31:0] word_c_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift in the current byte and advance the modulo-4 byte counter
  always_comb begin
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    word_valid_c_o = byte_valid_i && (cnt_q == 2'd3);
    word_c_o       = {shift_q, byte_i};
    if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Shift register and byte counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: header word N, then N big-endian words into BRAM, then a status byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic          clk,
  input logic          rstn,
  inst_loader_if.slave bus
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wd_q, mem_wd_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                pk_valid_c;
  logic                word_valid_c;
  logic [31:0]         word_c;

  byte_packer u_pack (
    .clk            (clk),
    .rstn           (rstn),
    .byte_valid_i   (pk_valid_c),
    .byte_i         (bus.rx_data),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c)
  );

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    pk_valid_c = 1'b0;

    case (state_q)
      S_HDR: begin
        pk_valid_c = bus.rx_valid;
        if (bus.rx_valid) busy_d = 1'b1;
        if (word_valid_c) begin
          if (word_c == 32'd0) begin
            state_d    = S_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_OK;
          end else if (word_c > 32'(DEPTH)) begin
            state_d    = S_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_ERR;
          end else begin
            state_d = S_DATA;
            n_d     = CNT_W'(word_c);
            wcnt_d  = '0;
          end
        end
      end

      S_DATA: begin
        // The cycle showing the final write closes the load; bytes there are dropped
        if (mem_we_q && (wcnt_q == n_q)) begin
          state_d    = S_ACK;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_OK;
        end else begin
          pk_valid_c = bus.rx_valid;
          if (word_valid_c) begin
            mem_we_d   = 1'b1;
            mem_addr_d = BASE_ADDR + ADDR_W'(wcnt_q);
            mem_wd_d   = word_c;
            wcnt_d     = wcnt_q + CNT_W'(1);
          end
        end
      end

      S_ACK: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          if (tx_data_q == ACK_ERR) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE, S_ERR: begin
        state_d = state_q;
      end

      default: state_d = S_HDR;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_HDR;
      n_q        <= '0;
      wcnt_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_wd_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader with a cycle-level behavioural reference model.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int PH_HDR  = 0;
  localparam int PH_DATA = 1;
  localparam int PH_ACK  = 2;
  localparam int PH_DONE = 3;
  localparam int PH_ERR  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  inst_loader_if bus ();

  inst_loader #(.BASE_ADDR('0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Per-cycle comparison counters and literal-check counters
  int n_cmp = 0, n_err = 0;
  int l_cmp = 0, l_err = 0;

  // Reference model state
  int          m_phase;
  int          m_nb;
  logic [31:0] m_hdr, m_word;
  longint      m_n;
  int          m_widx;
  bit          m_go_ack;
  logic        e_we, e_txv, e_busy, e_done, e_err;
  int          e_addr;
  logic [31:0] e_wd;
  logic [7:0]  e_txd;

  logic [31:0] bmem [16];
  logic [31:0] wq [16];

  // Reference model: spec rules evaluated on each accepted clock edge
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = PH_HDR; m_nb = 0; m_hdr = '0; m_word = '0; m_n = 0;
      m_widx = 0; m_go_ack = 0;
      e_we = 0; e_addr = 0; e_wd = '0; e_txv = 0; e_txd = '0;
      e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      e_we = 0;
      case (m_phase)
        PH_HDR: if (bus.rx_valid) begin
          e_busy = 1;
          m_hdr  = {m_hdr[23:0], bus.rx_data};
          m_nb++;
          if (m_nb == 4) begin
            m_nb = 0;
            m_n  = longint'(m_hdr);
            if (m_n == 0) begin
              m_phase = PH_ACK; e_txv = 1; e_txd = 8'hAA;
            end else if (m_n > 8192) begin
              m_phase = PH_ACK; e_txv = 1; e_txd = 8'hEE;
            end else begin
              m_phase = PH_DATA; m_widx = 0;
            end
          end
        end
        PH_DATA: begin
          if (m_go_ack) begin
            m_go_ack = 0; m_phase = PH_ACK; e_txv = 1; e_txd = 8'hAA;
          end else if (bus.rx_valid) begin
            m_word = {m_word[23:0], bus.rx_data};
            m_nb++;
            if (m_nb == 4) begin
              m_nb = 0;
              e_we = 1; e_addr = m_widx; e_wd = m_word;
              m_widx++;
              if (m_widx == m_n) m_go_ack = 1;
            end
          end
        end
        PH_ACK: if (e_txv && bus.tx_ready) begin
          e_txv = 0; e_busy = 0;
          if (e_txd == 8'hAA) begin e_done = 1; m_phase = PH_DONE; end
          else begin e_err = 1; m_phase = PH_ERR; end
        end
        default: ;
      endcase
    end
  end

  // Compare DUT against the model on every falling edge; capture memory writes
  always @(negedge clk) begin
    n_cmp++;
    if (bus.mem_we !== e_we || bus.busy !== e_busy || bus.done !== e_done ||
        bus.err !== e_err || bus.tx_valid !== e_txv ||
        (e_we && (bus.mem_addr !== ADDR_W'(e_addr) || bus.mem_wd !== e_wd)) ||
        (e_txv && bus.tx_data !== e_txd)) begin
      n_err++;
      $display("FAIL cycle t=%0t got we=%b addr=%h wd=%h txv=%b txd=%h busy=%b done=%b err=%b | exp we=%b addr=%h wd=%h txv=%b txd=%h busy=%b done=%b err=%b",
               $time, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.tx_valid, bus.tx_data,
               bus.busy, bus.done, bus.err, e_we, ADDR_W'(e_addr), e_wd, e_txv, e_txd,
               e_busy, e_done, e_err);
    end
    if (bus.mem_we === 1'b1 && bus.mem_addr < ADDR_W'(16))
      bmem[bus.mem_addr[3:0]] = bus.mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    l_cmp++;
    if (act !== exp) begin
      l_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    send_byte(w[31:24], $urandom_range(maxgap, 0));
    send_byte(w[23:16], $urandom_range(maxgap, 0));
    send_byte(w[15:8],  $urandom_range(maxgap, 0));
    send_byte(w[7:0],   $urandom_range(maxgap, 0));
  endtask

  // Wait for the status byte, optionally stall with stray rx bytes, then accept it
  task automatic take_ack(input logic [7:0] exp_txd, input int stall, input int extra);
    int i;
    for (i = 0; i < 40000; i++) begin
      if (bus.tx_valid === 1'b1) break;
      @(negedge clk);
    end
    if (i == 40000) begin
      l_cmp++; l_err++;
      $display("FAIL tx_valid_timeout got 0 expected 1");
    end
    chk("tx_data", 32'(bus.tx_data), 32'(exp_txd));
    for (int k = 0; k < extra; k++) send_byte(8'($urandom), 1);
    repeat (stall) @(negedge clk);
    chk("busy_stall", 32'(bus.busy), 32'd1);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    chk("tx_valid_after", 32'(bus.tx_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wd",   bus.mem_wd,        32'd0);
    chk("rst_txv_busy_done_err",
        32'({bus.tx_valid, bus.busy, bus.done, bus.err}), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic load(input int n, input int maxgap, input int stall, input int extra);
    logic [31:0] w;
    send_word(32'(n), maxgap);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (i < 16) wq[i] = w;
      send_word(w, maxgap);
    end
    take_ack(8'hAA, stall, extra);
    for (int i = 0; i < n && i < 16; i++) chk("load_word", bmem[i], wq[i]);
    chk("load_done", 32'({bus.done, bus.err}), 32'b10);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_flags", 32'({bus.mem_we, bus.tx_valid, bus.busy, bus.done, bus.err}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Normal load, one byte every 10 cycles
    send_word(32'd2, 0);
    foreach (wq[i]) wq[i] = '0;
    send_byte(8'hDE, 9); send_byte(8'hAD, 9); send_byte(8'hBE, 9); send_byte(8'hEF, 9);
    send_byte(8'h01, 9); send_byte(8'h23, 9); send_byte(8'h45, 9); send_byte(8'h67, 9);
    take_ack(8'hAA, 0, 0);
    chk("normal_w0", bmem[0], 32'hDEADBEEF);
    chk("normal_w1", bmem[1], 32'h01234567);
    chk("normal_done_err", 32'({bus.done, bus.err}), 32'b10);

    // Terminal state ignores further bytes
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(3, 0));
    chk("terminal_done", 32'(bus.done), 32'd1);

    // Back-to-back bytes
    do_reset();
    load(3, 0, 0, 0);

    // Zero header
    do_reset();
    send_word(32'h0000_0000, 1);
    take_ack(8'hAA, 2, 0);
    chk("zero_done_err", 32'({bus.done, bus.err}), 32'b10);

    // Oversized headers
    do_reset();
    send_word(32'h0000_2001, 1);
    take_ack(8'hEE, 3, 0);
    chk("big_done_err", 32'({bus.done, bus.err}), 32'b01);
    do_reset();
    send_word(32'hFFFF_FFFF, 0);
    take_ack(8'hEE, 0, 0);
    chk("huge_done_err", 32'({bus.done, bus.err}), 32'b01);

    // Backpressure with stray rx bytes during the stall
    do_reset();
    load(2, 3, 20, 5);

    // Random loads
    for (int r = 0; r < 6; r++) begin
      do_reset();
      load($urandom_range(6, 1), $urandom_range(2, 0), $urandom_range(5, 0), $urandom_range(3, 0));
    end

    // Maximum word count, back-to-back
    do_reset();
    load(8192, 0, 1, 0);

    // Reset in the middle of a load, then a fresh single-word load
    do_reset();
    send_word(32'd4, 1);
    send_word(32'h11223344, 1);
    send_byte(8'h55, 1); send_byte(8'h66, 1);
    do_reset();
    chk("abort_kept_w0", bmem[0], 32'h11223344);
    send_word(32'd1, 1);
    send_word(32'hCAFEF00D, 1);
    take_ack(8'hAA, 1, 0);
    chk("fresh_w0", bmem[0], 32'hCAFEF00D);
    chk("fresh_done_err", 32'({bus.done, bus.err}), 32'b10);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + l_cmp, n_err + l_err);
    $finish;
  end

endmodule
